// File: rtl/softmax_seq_pkg.sv
// softmax_seq_pkg
// Shared definitions for the sequential softmax block:
//   - default parameter values (channel count, input width, output width)
//   - FSM state encoding
//   - clog2 helper usable in parameter expressions
package softmax_seq_pkg;

    localparam int N_CH_DEFAULT  = 10;
    localparam int W_IN_DEFAULT  = 8;
    localparam int W_OUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAX  = 3'd1,
        EXP  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Smallest r with 2**r >= n (at least 1, so a 2-channel index still has a bit).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/softmax_seq_divider.sv
// seq_divider
// Restoring divider, one quotient bit per cycle, WQ cycles after the load.
// Computes floor((dividend_hi * 2**WQ + dividend_lo) / divisor); the caller
// guarantees dividend_hi < divisor so the quotient fits in WQ bits.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears all state)
//   start           load operands (only honoured while not busy)
//   dividend_hi/lo  upper WD bits / lower WQ bits of the dividend
//   divisor         WD-bit divisor (non-zero)
//   busy            a division is in progress
//   done            high during the cycle performing the final step
//   quotient        final quotient, valid while done is high
module seq_divider
    import softmax_seq_pkg::*;
#(
    parameter int WQ = 16,
    parameter int WD = 20
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [WD-1:0] dividend_hi,
    input  logic [WQ-1:0] dividend_lo,
    input  logic [WD-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WQ-1:0] quotient
);

    localparam int CW = clog2(WQ);

    logic [WD-1:0] rem_reg;
    logic [WQ-1:0] lo_reg;
    logic [WQ-1:0] q_reg;
    logic [WD-1:0] den_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;

    logic [WD:0]   trial;
    logic          ge;
    logic [WD-1:0] rem_next;
    logic [WQ-1:0] q_next;
    logic [WD:0]   trial_sub;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    assign trial     = {rem_reg, lo_reg[WQ-1]};
    assign ge        = (trial >= {1'b0, den_reg});
    assign trial_sub = trial - {1'b0, den_reg};
    assign rem_next  = ge ? trial_sub[WD-1:0] : trial[WD-1:0];
    assign q_next    = {q_reg[WQ-2:0], ge};

    assign busy     = busy_reg;
    assign done     = busy_reg && (cnt_reg == CW'(WQ - 1));
    assign quotient = q_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg  <= '0;
            lo_reg   <= '0;
            q_reg    <= '0;
            den_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start && !busy_reg) begin
            rem_reg  <= dividend_hi;
            lo_reg   <= dividend_lo;
            q_reg    <= '0;
            den_reg  <= divisor;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            rem_reg <= rem_next;
            lo_reg  <= {lo_reg[WQ-2:0], 1'b0};
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/softmax_seq.sv
// softmax_seq
// Sequential base-2 softmax over N_CH signed logits.
//   MAX : register the maximum logit and its (lowest) index
//   EXP : p_i = 2**(W_OUT-1+x_i-xmax) (0 when below one LSB), S = sum p_i
//   DIV : y_i = floor(p_i * 2**(W_OUT-1) / S), one channel at a time on a
//         shared restoring divider (W_OUT+1 cycles per channel)
//   DONE: present y, argmax index and confidence flag until accepted
// Argmax-only mode skips DIV and returns a one-hot 1.0 at the argmax channel.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (ready only in IDLE)
//   in_data               packed signed logits, channel i at [W_IN*i +: W_IN]
//   mode_argmax           1 = argmax-only fast mode
//   thr                   confidence threshold, unsigned Q1.(W_OUT-1)
//   out_valid/out_ready   output handshake
//   out_data              packed probabilities, channel i at [W_OUT*i +: W_OUT]
//   out_idx               argmax channel
//   out_conf              out_data[out_idx] >= thr
module softmax_seq
    import softmax_seq_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int W_IN  = W_IN_DEFAULT,
    parameter int W_OUT = W_OUT_DEFAULT,
    localparam int IW   = clog2(N_CH)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*W_IN-1:0]  in_data,
    input  logic                  mode_argmax,
    input  logic [W_OUT-1:0]      thr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*W_OUT-1:0] out_data,
    output logic [IW-1:0]         out_idx,
    output logic                  out_conf
);

    localparam int SW = W_OUT + IW;
    localparam logic [W_OUT-1:0] ONE_Q = {1'b1, {(W_OUT-1){1'b0}}};

    state_t                  state_reg;
    logic signed [W_IN-1:0]  x_reg [N_CH];
    logic                    mode_reg;
    logic [W_OUT-1:0]        thr_reg;
    logic signed [W_IN-1:0]  xmax_reg, xmax_next;
    logic [IW-1:0]           amax_reg, amax_next;
    logic [W_OUT-1:0]        p_reg  [N_CH];
    logic [W_OUT-1:0]        p_next [N_CH];
    logic [SW-1:0]           sum_reg, sum_next;
    logic [IW-1:0]           ch_reg;
    logic                    out_valid_reg;
    logic [N_CH*W_OUT-1:0]   out_data_reg;
    logic [IW-1:0]           out_idx_reg;
    logic                    out_conf_reg;
    logic [N_CH*W_OUT-1:0]   onehot;

    logic                    div_start, div_busy, div_done;
    logic [W_OUT-1:0]        div_q;
    logic [W_OUT-1:0]        p_sel;
    logic [SW-1:0]           div_hi;
    logic [W_OUT-1:0]        div_lo;

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign out_conf  = out_conf_reg;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        xmax_next = x_reg[0];
        amax_next = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (x_reg[i] > xmax_next) begin
                xmax_next = x_reg[i];
                amax_next = IW'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_exp
            logic signed [W_IN:0] d;
            logic [W_IN:0]        nd;
            // d = x - xmax is never positive; nd = -d is the right-shift amount.
            // Shifting by W_OUT or more yields 0, which covers the underflow case.
            assign d  = $signed({x_reg[gi][W_IN-1], x_reg[gi]})
                      - $signed({xmax_reg[W_IN-1], xmax_reg});
            assign nd = -d;
            assign p_next[gi] = ONE_Q >> nd;
            assign onehot[gi*W_OUT +: W_OUT] = (amax_reg == IW'(gi)) ? ONE_Q : '0;
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum_next = sum_next + SW'(p_next[i]);
        end
    end

    // Dividend p * 2**(W_OUT-1) split into the divider's hi/lo halves.
    // hi = p >> 1 is always below S because p <= S.
    assign p_sel     = p_reg[ch_reg];
    assign div_hi    = SW'(p_sel >> 1);
    assign div_lo    = {p_sel[0], {(W_OUT-1){1'b0}}};
    assign div_start = (state_reg == DIV) && !div_busy;

    seq_divider #(
        .WQ (W_OUT),
        .WD (SW)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (div_start),
        .dividend_hi (div_hi),
        .dividend_lo (div_lo),
        .divisor     (sum_reg),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b0;
            thr_reg       <= '0;
            xmax_reg      <= '0;
            amax_reg      <= '0;
            sum_reg       <= '0;
            ch_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_conf_reg  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                x_reg[i] <= '0;
                p_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_CH; i++) begin
                            x_reg[i] <= in_data[i*W_IN +: W_IN];
                        end
                        mode_reg     <= mode_argmax;
                        thr_reg      <= thr;
                        out_data_reg <= '0;
                        out_idx_reg  <= '0;
                        out_conf_reg <= 1'b0;
                        state_reg    <= MAX;
                    end
                end
                MAX: begin
                    xmax_reg  <= xmax_next;
                    amax_reg  <= amax_next;
                    state_reg <= EXP;
                end
                EXP: begin
                    for (int i = 0; i < N_CH; i++) begin
                        p_reg[i] <= p_next[i];
                    end
                    sum_reg   <= sum_next;
                    ch_reg    <= '0;
                    state_reg <= mode_reg ? DONE : DIV;
                end
                DIV: begin
                    // Results land directly in the output register; out_valid
                    // stays low until DONE so the partial vector is never visible.
                    if (div_done) begin
                        out_data_reg[ch_reg*W_OUT +: W_OUT] <= div_q;
                        if (ch_reg == IW'(N_CH - 1)) begin
                            state_reg <= DONE;
                        end else begin
                            ch_reg <= ch_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle finalises index/confidence and raises valid.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_idx_reg   <= amax_reg;
                        if (mode_reg) begin
                            out_data_reg <= onehot;
                            out_conf_reg <= 1'b1;
                        end else begin
                            out_conf_reg <= (out_data_reg[amax_reg*W_OUT +: W_OUT] >= thr_reg);
                        end
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_seq.sv
// tb_softmax_seq
// Directed bench for softmax_seq with N_CH=4, W_IN=8, W_OUT=16.
// Expected probabilities are hand-computed constants.
module tb_softmax_seq;

    localparam int N_CH  = 4;
    localparam int W_IN  = 8;
    localparam int W_OUT = 16;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CH*W_IN-1:0]  in_data;
    logic                  mode_argmax;
    logic [W_OUT-1:0]      thr;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_CH*W_OUT-1:0] out_data;
    logic [1:0]            out_idx;
    logic                  out_conf;

    int checks = 0;
    int errors = 0;

    softmax_seq #(
        .N_CH  (N_CH),
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode_argmax (mode_argmax),
        .thr         (thr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_conf    (out_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a vector and return 1 time unit after the transfer edge.
    task automatic send(input logic [31:0] x, input logic m, input logic [15:0] t);
        int n;
        n = 0;
        @(negedge clk);
        in_data     = x;
        mode_argmax = m;
        thr         = t;
        in_valid    = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_at_send", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        // Scramble the inputs: nothing latched may follow them.
        in_data     = 32'hA5A5_5A5A;
        mode_argmax = ~m;
        thr         = ~t;
    endtask

    // Edges from the transfer edge to the one that raised out_valid (0 = timeout).
    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string pfx, input int lat, input int exp_lat,
                                input logic [63:0] exp_data, input logic [1:0] exp_idx,
                                input logic exp_conf);
        $display("txn %s lat=%0d data=%h idx=%0d conf=%0b", pfx, lat, out_data, out_idx, out_conf);
        check({pfx, "_latency"}, 64'(lat), 64'(exp_lat));
        check({pfx, "_data"}, out_data, exp_data);
        check({pfx, "_idx"}, 64'(out_idx), 64'(exp_idx));
        check({pfx, "_conf"}, 64'(out_conf), 64'(exp_conf));
    endtask

    task automatic consume(input string pfx);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({pfx, "_valid_dropped"}, 64'(out_valid), 64'd0);
        check({pfx, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int  lat;
        bit  seen;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        mode_argmax = 1'b0;
        thr         = '0;
        out_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_conf", 64'(out_conf), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // All logits equal: y = 0.25 each
        send(32'h0000_0000, 1'b0, 16'd8192);
        wait_out(lat);
        check_result("equal", lat, 71, 64'h2000_2000_2000_2000, 2'd0, 1'b1);
        consume("equal");

        // x = [3,0,0,0]: S = 45056, y = [23831,2978,2978,2978]; then backpressure
        send(32'h0000_0003, 1'b0, 16'd16384);
        wait_out(lat);
        check_result("peak", lat, 71, 64'h0BA2_0BA2_0BA2_5D17, 2'd0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, 64'h0BA2_0BA2_0BA2_5D17);
            check("hold_idx", 64'(out_idx), 64'd0);
            check("hold_conf", 64'(out_conf), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        consume("peak");

        // x = [100,-100,-100,-100]: other channels underflow; 32768 < thr -> conf 0
        send(32'h9C9C_9C64, 1'b0, 16'hFFFF);
        wait_out(lat);
        check_result("underflow", lat, 71, 64'h0000_0000_0000_8000, 2'd0, 1'b0);
        consume("underflow");

        // Argmax mode, tie between channels 0 and 1 -> lowest index
        send(32'h0101_0505, 1'b1, 16'hFFFF);
        wait_out(lat);
        check_result("argmax_tie", lat, 3, 64'h0000_0000_0000_8000, 2'd0, 1'b1);
        consume("argmax_tie");

        // Argmax mode, x = [-3,7,9,9] -> channel 2
        send(32'h0909_07FD, 1'b1, 16'h0000);
        wait_out(lat);
        check_result("argmax_ch2", lat, 3, 64'h0000_8000_0000_0000, 2'd2, 1'b1);
        consume("argmax_ch2");

        // Reset mid-DIV aborts, then a fresh vector computes correctly
        send(32'h0000_0003, 1'b0, 16'd16384);
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", out_data, 64'd0);
        check("abort_out_idx", 64'(out_idx), 64'd0);
        check("abort_out_conf", 64'(out_conf), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        check("abort_idle_ready", 64'(in_ready), 64'd1);

        send(32'h0000_0003, 1'b0, 16'd16384);
        wait_out(lat);
        check_result("after_abort", lat, 71, 64'h0BA2_0BA2_0BA2_5D17, 2'd0, 1'b1);
        consume("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softmax_seq.md
SOFTMAX_SEQ -- requirements
Module: softmax_seq

Interface
REQ-001 The block SHALL take parameter N_CH, default 10, meaning number of classifier channels (2..64).
REQ-002 The block SHALL take parameter W_IN, default 8, meaning signed input logit width.
REQ-003 The block SHALL take parameter W_OUT, default 16, meaning unsigned output probability width, format Q1.(W_OUT-1).
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1, input vector offered.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a vector.
REQ-008 The block SHALL have port in_data, input, N_CH*W_IN, packed signed logits, channel i at bits [W_IN*(i+1)-1 : W_IN*i].
REQ-009 The block SHALL have port mode_argmax, input, 1, 1 = argmax-only fast mode.
REQ-010 The block SHALL have port thr, input, W_OUT, confidence threshold for early termination.
REQ-011 The block SHALL have port out_valid, output, 1, result available.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 The block SHALL have port out_data, output, N_CH*W_OUT, packed probabilities, same packing as in_data.
REQ-014 The block SHALL have port out_idx, output, clog2(N_CH), argmax channel.
REQ-015 The block SHALL have port out_conf, output, 1, out_data[out_idx] >= thr, for early termination.

Function
REQ-016 The FSM SHALL have states IDLE, MAX, EXP, DIV and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer (in_valid & in_ready) latches in_data, mode_argmax and thr and moves the FSM to MAX.
REQ-018 MAX (1 cycle) SHALL register xmax and argmax; on a tie the lowest index wins.
REQ-019 EXP (1 cycle) SHALL compute, per channel, d_i = x_i - xmax at W_IN+1 bits, always <= 0.
REQ-020 EXP SHALL set p_i = 2^(W_OUT-1+d_i) when d_i >= -(W_OUT-1), else 0.
REQ-021 EXP SHALL register the sum S of all p_i at width W_OUT+clog2(N_CH) with no overflow.
REQ-022 From EXP, when mode_argmax=1 the FSM SHALL go to DONE with out_data all zero except channel argmax = 2^(W_OUT-1), and out_conf=1.
REQ-023 From EXP, when mode_argmax=0 the FSM SHALL go to DIV.
REQ-024 DIV SHALL process channels 0..N_CH-1 in order, each taking W_OUT+1 cycles (1 load plus W_OUT restoring steps).
REQ-025 Each DIV result SHALL be y_i = floor(p_i * 2^(W_OUT-1) / S), truncated, never exceeding 2^(W_OUT-1).
REQ-026 After the last channel the FSM SHALL go to DONE.
REQ-027 Latency SHALL be: transfer at edge t -> out_valid at edge t+3+N_CH*(W_OUT+1) in softmax mode (173 with defaults), or t+3 in argmax mode.
REQ-028 In DONE, out_valid SHALL be 1 and out_data/out_idx/out_conf SHALL be stable until out_valid & out_ready, after which the FSM returns to IDLE.
REQ-029 A new input SHALL NOT be accepted in the same cycle as the output transfer.
REQ-030 out_conf SHALL be computed as the unsigned compare y[argmax] >= thr.
REQ-031 in_data changes while not in IDLE SHALL have no effect.

Reset
REQ-032 While reset is asserted, the FSM SHALL go to IDLE.
REQ-033 While reset is asserted, in_ready SHALL be 0, and 1 in the first cycle after reset deasserts.
REQ-034 While reset is asserted, out_valid, out_data, out_idx and out_conf SHALL all be 0.
REQ-035 While reset is asserted, the divider and channel counter SHALL clear.
REQ-036 Reset asserted in any state, including mid-DIV, SHALL abort the computation with no output produced.

Structure
REQ-037 The shared package SHALL hold the FSM state encoding, clog2 helper, and default values of N_CH/W_IN/W_OUT.
REQ-038 The restoring divider SHALL be one sub-module, seq_divider (start/done, W_OUT-cycle quotient), instantiated once and time-shared across channels.

Verification
REQ-039 The bench SHALL cover: N_CH=4, W_OUT=16, all x=0 -> y=8192 each, out_idx=0, out_conf=1 with thr=8192.
REQ-040 The bench SHALL cover: N_CH=4, x=[3,0,0,0] -> S=45056, y=[23831,2978,2978,2978], out_idx=0, out_conf=1 with thr=16384, out_valid exactly 71 edges after the transfer.
REQ-041 The bench SHALL cover: W_IN=8, x=[100,-100,-100,-100] -> d=-200 underflows, y=[32768,0,0,0].
REQ-042 The bench SHALL cover: mode_argmax=1, x=[5,5,1,1] -> out_idx=0, y=[32768,0,0,0], out_valid 3 edges after the transfer.
REQ-043 The bench SHALL cover: out_ready held 0 for 20 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE next cycle.
REQ-044 The bench SHALL cover: reset pulsed mid-DIV -> IDLE, all outputs 0, no out_valid; a subsequent vector gives the correct result.
